code_verifier: RTL

//  Synchronous, parametrised keypad-code verifier for the digital lock. Collects

---
 rtl/code_verifier.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/code_verifier.sv
// Keypad code verifier: buffers DIGITS key digits and checks them on ENTER against
// the master code, the user code, or a staged new user code. Define LOCKOUT_EN for the failure lockout.
module code_verifier #(
  parameter int unsigned               DIGITS      = 6,
  parameter int unsigned               DW          = 4,
  parameter logic [DW-1:0]             KEY_CLEAR   = 4'd7,
  parameter logic [DW-1:0]             KEY_ENTER   = 4'd8,
  parameter logic [DIGITS*DW-1:0]      DEFAULT_UC  = 24'h123456,
  parameter logic [DIGITS*DW-1:0]      MASTER_PC   = 24'h666666,
  parameter int unsigned               MAX_FAIL    = 3,
  parameter int unsigned               LOCK_CYCLES = 12_000_000
) (
  input  logic                          hwclk,
  input  logic                          rst,
  input  logic                          key_valid,
  input  logic [DW-1:0]                 key,
  input  logic                          read_en,
  input  logic [1:0]                    mode,
  input  logic                          commit,
  output logic                          result_valid,
  output logic                          correct,
  output logic [$clog2(DIGITS+1)-1:0]   entry_count,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_count,
  output logic                          locked,
  output logic [DIGITS*DW-1:0]          uc_out
);

  localparam int W  = DIGITS * DW;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    CMP_PC   = 2'b00,
    CMP_UC   = 2'b01,
    MATCH_UC = 2'b10,
    STAGE_UC = 2'b11
  } mode_t;

  mode_t          cur_mode;
  logic           accept;
  logic           enter_acc;
  logic           full;
  logic           enter_ok;
  logic           unlock;
  logic [W-1:0]   buffer;
  logic [W-1:0]   staged;
  logic           staged_ok;
  logic [CW-1:0]  count;

  assign cur_mode    = mode_t'(mode);
  assign accept      = key_valid & read_en & ~locked;
  assign enter_acc   = accept & (key == KEY_ENTER);
  assign full        = (count == CW'(DIGITS));
  assign entry_count = count;

  // Verdict for an ENTER this cycle; any short entry is a failure.
  always_comb begin
    enter_ok = 1'b0;
    if (full) begin
      case (cur_mode)
        CMP_PC:   enter_ok = (buffer == MASTER_PC);
        CMP_UC:   enter_ok = (buffer == uc_out);
        MATCH_UC: enter_ok = (buffer == staged);
        STAGE_UC: enter_ok = 1'b1;
        default:  enter_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge hwclk) begin
    if (rst) begin
      buffer       <= '0;
      count        <= '0;
      correct      <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (unlock) begin
        buffer <= '0;
        count  <= '0;
      end else if (accept) begin
        if (key == KEY_CLEAR) begin
          buffer  <= '0;
          count   <= '0;
          correct <= 1'b0;
        end else if (key == KEY_ENTER) begin
          buffer       <= '0;
          count        <= '0;
          correct      <= enter_ok;
          result_valid <= 1'b1;
        end else begin
          buffer  <= (buffer << DW) | W'(key);
          if (!full) count <= count + 1'b1;
          correct <= 1'b0;
        end
      end
    end
  end

  // Commit uses the pre-edge staged state; a same-cycle MATCH_UC verdict wins on staged_ok.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      staged    <= '0;
      staged_ok <= 1'b0;
      uc_out    <= DEFAULT_UC;
    end else begin
      if (commit && staged_ok) begin
        uc_out    <= staged;
        staged_ok <= 1'b0;
      end
      if (enter_acc && full) begin
        if (cur_mode == STAGE_UC) begin
          staged    <= buffer;
          staged_ok <= 1'b0;
        end else if (cur_mode == MATCH_UC) begin
          staged_ok <= enter_ok;
        end
      end
    end
  end

`ifdef LOCKOUT_EN
  localparam int TW = $clog2(LOCK_CYCLES + 2);

  logic [TW-1:0] timer;
  logic [FW-1:0] fails;
  logic          lock_q;
  logic          cmp_mode;

  assign cmp_mode   = (cur_mode == CMP_PC) || (cur_mode == CMP_UC);
  assign unlock     = lock_q && (timer <= TW'(1));
  assign locked     = lock_q;
  assign fail_count = fails;

  // Lockout starts the cycle after the failure count saturates and lasts LOCK_CYCLES cycles.
  always_ff @(posedge hwclk) begin
    if (rst) begin
      fails  <= '0;
      lock_q <= 1'b0;
      timer  <= '0;
    end else if (lock_q) begin
      if (timer <= TW'(1)) begin
        lock_q <= 1'b0;
        fails  <= '0;
        timer  <= '0;
      end else begin
        timer <= timer - 1'b1;
      end
    end else begin
      if (fails == FW'(MAX_FAIL)) begin
        lock_q <= 1'b1;
        timer  <= TW'(LOCK_CYCLES);
      end
      if (enter_acc && cmp_mode) begin
        if (enter_ok) fails <= '0;
        else if (fails != FW'(MAX_FAIL)) fails <= fails + 1'b1;
      end
    end
  end
`else
  assign unlock     = 1'b0;
  assign locked     = 1'b0;
  assign fail_count = '0;
`endif

endmodule
